// File: rtl/macu_pkg.sv
// Shared constants and helpers for the macu_acc MAC cell.
// The mode encoding, product width and the OW+1 -> OW signed clamp.
package macu_pkg;

   localparam logic MODE_CASC = 1'b0;
   localparam logic MODE_ACC  = 1'b1;

   localparam int DW_DEF = 8;
   localparam int OW_DEF = 20;
   localparam int PW     = 2 * DW_DEF + 2;

   // Clamp a sign-extended sum to the signed range of an ow-bit word (ow <= 64).
   function automatic logic [63:0] sat_ow(input logic signed [64:0] s, input int ow);
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      hi = (65'sd1 <<< (ow - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (ow - 1));
      if (s > hi)
         return hi[63:0];
      else if (s < lo)
         return lo[63:0];
      else
         return s[63:0];
   endfunction

endpackage

// File: rtl/mul_sx.sv
// (DW+1)x(DW+1) signed combinational multiplier; a plain product so it maps to a DSP.
module mul_sx #(
   parameter int DW = 8
) (
   input  logic signed [DW:0]     i_a,
   input  logic signed [DW:0]     i_b,
   output logic signed [2*DW+1:0] o_p
);

   assign o_p = i_a * i_b;

endmodule

// File: rtl/macu_acc.sv
// Systolic PE MAC cell: double-buffered stationary weight, 3-stage pipeline,
// cascade-add or local accumulate with optional saturation and sticky overflow.
module macu_acc
   import macu_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int OW = OW_DEF   // must be >= 2*DW+2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DW-1:0]        xi,
   input  logic                 x_vld,
   input  logic                 x_sgn,
   input  logic                 w_sgn,
   input  logic                 mode,
   input  logic                 acc_clr,
   input  logic [DW-1:0]        wi,
   input  logic                 w_ld,
   input  logic                 w_swap,
   input  logic signed [OW-1:0] ci,
   input  logic                 sat_en,
   output logic [DW-1:0]        xo,
   output logic                 xo_vld,
   output logic signed [OW-1:0] co,
   output logic                 co_vld,
   output logic                 ovf
);

   localparam int PWL = 2 * DW + 2;

   logic [DW-1:0]        r_wsh;
   logic [DW-1:0]        r_wact;

   logic [DW-1:0]        r_x1;
   logic                 r_v1;
   logic                 r_xs1;
   logic                 r_ws1;
   logic                 r_m1;
   logic                 r_clr1;

   logic signed [OW-1:0] r_p2;
   logic signed [OW-1:0] r_ci2;
   logic                 r_v2;
   logic                 r_m2;
   logic                 r_clr2;

   logic signed [OW-1:0] r_co;
   logic signed [OW-1:0] r_acc;
   logic                 r_co_vld;
   logic                 r_ovf;

   logic signed [DW:0]    w_a;
   logic signed [DW:0]    w_b;
   logic signed [PWL-1:0] w_p;
   logic signed [OW-1:0]  w_base;
   logic signed [OW:0]    w_sum;
   logic signed [OW-1:0]  w_sat;
   logic signed [OW-1:0]  w_res;
   logic                  w_oor;

   // Weight buffers: a simultaneous load+swap bypasses wi straight to the active weight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wsh  <= '0;
         r_wact <= '0;
      end else if (w_ld && w_swap) begin
         r_wsh  <= wi;
         r_wact <= wi;
      end else begin
         if (w_swap)
            r_wact <= r_wsh;
         if (w_ld)
            r_wsh <= wi;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x1   <= '0;
         r_v1   <= 1'b0;
         r_xs1  <= 1'b0;
         r_ws1  <= 1'b0;
         r_m1   <= MODE_CASC;
         r_clr1 <= 1'b0;
      end else begin
         r_x1   <= xi;
         r_v1   <= x_vld;
         r_xs1  <= x_sgn;
         r_ws1  <= w_sgn;
         r_m1   <= mode;
         r_clr1 <= acc_clr;
      end
   end

   assign w_a = {r_xs1 & r_x1[DW-1], r_x1};
   assign w_b = {r_ws1 & r_wact[DW-1], r_wact};

   mul_sx #(.DW(DW)) u_mul (
      .i_a (w_a),
      .i_b (w_b),
      .o_p (w_p)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_p2   <= '0;
         r_ci2  <= '0;
         r_v2   <= 1'b0;
         r_m2   <= MODE_CASC;
         r_clr2 <= 1'b0;
      end else begin
         r_p2   <= OW'(w_p);
         r_ci2  <= ci;
         r_v2   <= r_v1;
         r_m2   <= r_m1;
         r_clr2 <= r_clr1;
      end
   end

   // One extra bit on the sum makes out-of-range a simple top-two-bits disagreement.
   assign w_base = (r_m2 == MODE_ACC) ? (r_clr2 ? '0 : r_acc) : r_ci2;
   assign w_sum  = {w_base[OW-1], w_base} + {r_p2[OW-1], r_p2};
   assign w_oor  = w_sum[OW] ^ w_sum[OW-1];
   assign w_sat  = OW'(sat_ow(65'(w_sum), OW));
   assign w_res  = sat_en ? w_sat : w_sum[OW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_co     <= '0;
         r_acc    <= '0;
         r_co_vld <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_co_vld <= r_v2;
         if (r_v2) begin
            r_co  <= w_res;
            r_ovf <= (r_clr2 ? 1'b0 : r_ovf) | w_oor;
            if (r_m2 == MODE_ACC)
               r_acc <= w_res;
         end else if (r_clr2) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
         end
      end
   end

   assign xo     = r_x1;
   assign xo_vld = r_v1;
   assign co     = r_co;
   assign co_vld = r_co_vld;
   assign ovf    = r_ovf;

endmodule
